// File: rtl/alarma_ring_ctrl.sv
// alarma_ring_ctrl
// Ring sequencer and arbiter for the shared alarm indicator. Two sources
// compete for one blinking output: chronometer expiry (fin_crono) and
// clock-alarm match (alarm_hit). The chronometer wins ties. Alarm rings
// may be snoozed up to MAX_SNOOZE times. A chronometer ring can interrupt
// a snooze, which freezes the snooze counter and resumes it afterwards.
//
// Handshake: ack and snooze are single-cycle strobes, already synchronised
// to CLK_Ring. They are sampled on the rising edge and have no ready path.
// fin_crono is a level input, held until clr_crono pulses. alarm_hit is a
// level input, and only its rising edges matter.
//
// Ports:
//   CLK_Ring   in   ring clock, rising edge
//   reset      in   asynchronous, active-high
//   fin_crono  in   chronometer finished (level)
//   alarm_hit  in   clock-alarm time match (level)
//   ack        in   dismiss strobe
//   snooze     in   snooze strobe
//   ring_en    out  indicator granted and ringing
//   band_parp  out  blink flag, 1 on the first ring cycle, then toggles
//   src        out  current/last grant (0 = chronometer, 1 = alarm)
//   clr_crono  out  one-cycle pulse clearing the chronometer flag
//   snoozing   out  alarm snooze in progress (also while frozen)
//   missed     out  sticky: a ring ended by timeout
//   dbg_state  out  FSM state (0 idle, 1 ring, 2 snooze)
module alarma_ring_ctrl #(
    parameter int RING_TICKS   = 60,
    parameter int SNOOZE_TICKS = 300,
    parameter int MAX_SNOOZE   = 3,
    parameter int CNT_W        = 9
) (
    input  logic       CLK_Ring,
    input  logic       reset,
    input  logic       fin_crono,
    input  logic       alarm_hit,
    input  logic       ack,
    input  logic       snooze,
    output logic       ring_en,
    output logic       band_parp,
    output logic       src,
    output logic       clr_crono,
    output logic       snoozing,
    output logic       missed,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RING   = 2'd1,
        S_SNOOZE = 2'd2
    } state_t;

    localparam int SN_W = $clog2(MAX_SNOOZE + 2);
    localparam logic [CNT_W-1:0] RING_LIM = CNT_W'(RING_TICKS);
    localparam logic [CNT_W-1:0] SNZ_LIM  = CNT_W'(SNOOZE_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [SN_W-1:0]  SN_LIM   = SN_W'(MAX_SNOOZE);
    localparam logic [SN_W-1:0]  SN_ONE   = SN_W'(1);

    state_t           state, state_n;
    logic             prev_c, prev_a;
    logic             pend_c, pend_c_n;
    logic             pend_a, pend_a_n;
    logic             src_q, src_n;
    logic             band_q, band_n;
    logic             clr_q, clr_n;
    logic             missed_q, missed_n;
    logic             frozen, frozen_n;
    logic [CNT_W-1:0] ring_cnt, ring_cnt_n;
    logic [CNT_W-1:0] snz_cnt, snz_cnt_n;
    logic [SN_W-1:0]  snz_num, snz_num_n;

    logic edge_c, edge_a, alarm_busy, want_c;

    // Previous-value registers reset to 0, so a level already high when
    // reset releases is treated as a fresh edge.
    assign edge_c = fin_crono & ~prev_c;
    assign edge_a = alarm_hit & ~prev_a;
    assign want_c = pend_c | edge_c;

    // Alarm edges are dropped while the alarm owns the indicator or is
    // snoozed (including a snooze frozen under a chronometer ring).
    assign alarm_busy = ((state == S_RING) && src_q) || (state == S_SNOOZE) || frozen;

    // State and datapath registers
    always_ff @(posedge CLK_Ring or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            prev_c   <= 1'b0;
            prev_a   <= 1'b0;
            pend_c   <= 1'b0;
            pend_a   <= 1'b0;
            src_q    <= 1'b0;
            band_q   <= 1'b0;
            clr_q    <= 1'b0;
            missed_q <= 1'b0;
            frozen   <= 1'b0;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            snz_num  <= '0;
        end else begin
            state    <= state_n;
            prev_c   <= fin_crono;
            prev_a   <= alarm_hit;
            pend_c   <= pend_c_n;
            pend_a   <= pend_a_n;
            src_q    <= src_n;
            band_q   <= band_n;
            clr_q    <= clr_n;
            missed_q <= missed_n;
            frozen   <= frozen_n;
            ring_cnt <= ring_cnt_n;
            snz_cnt  <= snz_cnt_n;
            snz_num  <= snz_num_n;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_n    = state;
        pend_c_n   = pend_c | edge_c;
        pend_a_n   = pend_a | (edge_a & ~alarm_busy);
        src_n      = src_q;
        band_n     = 1'b0;
        clr_n      = 1'b0;
        missed_n   = missed_q;
        frozen_n   = frozen;
        ring_cnt_n = ring_cnt;
        snz_cnt_n  = snz_cnt;
        snz_num_n  = snz_num;

        case (state)
            S_IDLE: begin
                if (want_c) begin
                    state_n    = S_RING;
                    src_n      = 1'b0;
                    pend_c_n   = 1'b0;
                    ring_cnt_n = CNT_ONE;
                    band_n     = 1'b1;
                end else if (pend_a | edge_a) begin
                    state_n    = S_RING;
                    src_n      = 1'b1;
                    pend_a_n   = 1'b0;
                    ring_cnt_n = CNT_ONE;
                    band_n     = 1'b1;
                end
            end

            S_RING: begin
                // ring_cnt holds the 1-based index of the current ring cycle.
                band_n     = ~band_q;
                ring_cnt_n = ring_cnt + CNT_ONE;
                if (ack || (!(snooze && src_q && (snz_num < SN_LIM)) && (ring_cnt >= RING_LIM))) begin
                    band_n = 1'b0;
                    if (ack) begin
                        missed_n = 1'b0;
                    end else begin
                        missed_n = 1'b1;
                    end
                    if (!src_q) begin
                        clr_n = 1'b1;
                        if (frozen) begin
                            state_n  = S_SNOOZE;
                            frozen_n = 1'b0;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        snz_num_n = '0;
                        state_n   = S_IDLE;
                    end
                end else if (snooze && src_q && (snz_num < SN_LIM)) begin
                    band_n    = 1'b0;
                    state_n   = S_SNOOZE;
                    snz_num_n = snz_num + SN_ONE;
                    snz_cnt_n = CNT_ONE;
                end
            end

            S_SNOOZE: begin
                // snz_cnt holds the 1-based index of the current snooze cycle.
                snz_cnt_n = snz_cnt + CNT_ONE;
                if (ack) begin
                    snz_num_n = '0;
                    state_n   = S_IDLE;
                end else if (want_c) begin
                    // The current cycle still counts as a snooze cycle; the
                    // counter then holds its value until the crono ring ends.
                    state_n    = S_RING;
                    src_n      = 1'b0;
                    pend_c_n   = 1'b0;
                    frozen_n   = 1'b1;
                    ring_cnt_n = CNT_ONE;
                    band_n     = 1'b1;
                    if (snz_cnt >= SNZ_LIM) begin
                        snz_cnt_n = snz_cnt;
                    end
                end else if (snz_cnt >= SNZ_LIM) begin
                    state_n    = S_RING;
                    src_n      = 1'b1;
                    ring_cnt_n = CNT_ONE;
                    band_n     = 1'b1;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        ring_en   = (state == S_RING);
        band_parp = band_q;
        src       = src_q;
        clr_crono = clr_q;
        snoozing  = (state == S_SNOOZE) || frozen;
        missed    = missed_q;
        dbg_state = state;
    end

endmodule

// File: tb/tb_alarma_ring_ctrl.sv
// Directed bench for alarma_ring_ctrl with default parameters
// (RING_TICKS=60, SNOOZE_TICKS=300, MAX_SNOOZE=3). Inputs are driven and
// outputs sampled on the falling edge of CLK_Ring.
module tb_alarma_ring_ctrl;

  logic       CLK_Ring;
  logic       reset;
  logic       fin_crono;
  logic       alarm_hit;
  logic       ack;
  logic       snooze;
  logic       ring_en;
  logic       band_parp;
  logic       src;
  logic       clr_crono;
  logic       snoozing;
  logic       missed;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [0:0] exp_q[$];

  alarma_ring_ctrl dut (
    .CLK_Ring  (CLK_Ring),
    .reset     (reset),
    .fin_crono (fin_crono),
    .alarm_hit (alarm_hit),
    .ack       (ack),
    .snooze    (snooze),
    .ring_en   (ring_en),
    .band_parp (band_parp),
    .src       (src),
    .clr_crono (clr_crono),
    .snoozing  (snoozing),
    .missed    (missed),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial begin
    CLK_Ring = 1'b0;
    forever #5 CLK_Ring = ~CLK_Ring;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK_Ring);
  endtask

  // Counts consecutive samples with ring_en == level, starting at the
  // current one; stops after bound samples.
  task automatic run_len(input logic level, input int bound, output int n);
    n = 0;
    while (ring_en == level && n < bound) begin
      n++;
      step();
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  initial begin
    int n;
    int rings;
    logic [0:0] exp_b;

    reset = 1'b1;
    fin_crono = 1'b0;
    alarm_hit = 1'b0;
    ack = 1'b0;
    snooze = 1'b0;
    repeat (3) step();
    check("rst_ring_en", ring_en, 0);
    check("rst_band", band_parp, 0);
    check("rst_src", src, 0);
    check("rst_clr", clr_crono, 0);
    check("rst_snoozing", snoozing, 0);
    check("rst_missed", missed, 0);
    reset = 1'b0;
    step();
    check("idle_ring_en", ring_en, 0);

    // 1: crono ring times out after 60 cycles
    for (int i = 0; i < 60; i++) exp_q.push_back(1'((i % 2) == 0));
    fin_crono = 1'b1;
    step();
    check("t1_src", src, 0);
    n = 0;
    while (ring_en && n < 100) begin
      exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
      check("t1_band", band_parp, exp_b);
      n++;
      step();
    end
    check("t1_len", n, 60);
    check("t1_missed", missed, 1);
    check("t1_clr", clr_crono, 1);
    fin_crono = 1'b0;
    step();
    check("t1_clr_once", clr_crono, 0);
    check("t1_idle", ring_en, 0);

    // 2: simultaneous sources, crono first, one idle cycle, then alarm
    fin_crono = 1'b1;
    alarm_hit = 1'b1;
    step();
    check("t2_c_ring", ring_en, 1);
    check("t2_c_src", src, 0);
    repeat (4) step();
    pulse_ack();
    check("t2_c_off", ring_en, 0);
    check("t2_c_clr", clr_crono, 1);
    check("t2_missed_clr", missed, 0);
    fin_crono = 1'b0;
    step();
    check("t2_a_ring", ring_en, 1);
    check("t2_a_src", src, 1);
    check("t2_a_band", band_parp, 1);
    check("t2_a_clr0", clr_crono, 0);
    repeat (4) step();
    pulse_ack();
    check("t2_a_off", ring_en, 0);
    check("t2_a_noclr", clr_crono, 0);
    alarm_hit = 1'b0;
    step();
    check("t2_idle", ring_en, 0);

    // 3: snoozes of 300 cycles, fourth snooze ignored
    alarm_hit = 1'b1;
    step();
    check("t3_ring", ring_en, 1);
    repeat (2) step();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    check("t3_snoozing", snoozing, 1);
    run_len(1'b0, 400, n);
    check("t3_snz1_len", n, 300);
    check("t3_rering_src", src, 1);
    for (int k = 0; k < 2; k++) begin
      snooze = 1'b1;
      step();
      snooze = 1'b0;
      run_len(1'b0, 400, n);
      check("t3_snz_len", n, 300);
    end
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    check("t3_4th_ignored", ring_en, 1);
    check("t3_4th_nosnz", snoozing, 0);
    pulse_ack();
    check("t3_off", ring_en, 0);
    alarm_hit = 1'b0;
    step();

    // 4: crono ring interrupts a snooze at snooze cycle 100
    alarm_hit = 1'b1;
    step();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    repeat (99) step();
    check("t4_pre_low", ring_en, 0);
    fin_crono = 1'b1;
    step();
    check("t4_c_ring", ring_en, 1);
    check("t4_c_src", src, 0);
    check("t4_frozen_snz", snoozing, 1);
    repeat (9) step();
    pulse_ack();
    fin_crono = 1'b0;
    check("t4_c_clr", clr_crono, 1);
    check("t4_resume_snz", snoozing, 1);
    run_len(1'b0, 400, n);
    check("t4_rest_len", n, 200);
    check("t4_a_src", src, 1);
    pulse_ack();
    alarm_hit = 1'b0;
    check("t4_off", ring_en, 0);
    check("t4_nosnz", snoozing, 0);

    // 5: snooze ignored on crono ring; ack cancels snooze; ack beats snooze
    fin_crono = 1'b1;
    step();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    check("t5_c_snz_ign", ring_en, 1);
    check("t5_c_nosnz", snoozing, 0);
    pulse_ack();
    fin_crono = 1'b0;
    check("t5_c_clr", clr_crono, 1);
    step();
    alarm_hit = 1'b1;
    step();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    check("t5_snoozing", snoozing, 1);
    repeat (5) step();
    pulse_ack();
    check("t5_cancel_snz", snoozing, 0);
    check("t5_cancel_ring", ring_en, 0);
    rings = 0;
    repeat (320) begin
      step();
      if (ring_en) rings++;
    end
    check("t5_no_rering", rings, 0);
    alarm_hit = 1'b0;
    step();
    alarm_hit = 1'b1;
    step();
    check("t5_a_ring", ring_en, 1);
    ack = 1'b1;
    snooze = 1'b1;
    step();
    ack = 1'b0;
    snooze = 1'b0;
    check("t5_ackwin_ring", ring_en, 0);
    check("t5_ackwin_snz", snoozing, 0);
    alarm_hit = 1'b0;
    step();

    // 6: reset mid-ring with fin_crono held high
    fin_crono = 1'b1;
    step();
    repeat (3) step();
    check("t6_ringing", ring_en, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_ring", ring_en, 0);
    check("t6_rst_band", band_parp, 0);
    check("t6_rst_clr", clr_crono, 0);
    check("t6_rst_snz", snoozing, 0);
    step();
    reset = 1'b0;
    check("t6_rel_idle", ring_en, 0);
    step();
    check("t6_restart", ring_en, 1);
    check("t6_band", band_parp, 1);
    check("t6_src", src, 0);
    pulse_ack();
    check("t6_clr", clr_crono, 1);
    fin_crono = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarma_ring_ctrl.md
# alarma_ring_ctrl

Ring sequencer and arbiter for the shared alarm indicator. Two event sources compete for the single blinking output: chronometer expiry (`fin_crono`) and clock-alarm match (`alarm_hit`). The block grants the output to one source at a time, produces the blink flag, and handles acknowledge, snooze and ring timeout. It clears the chronometer's finish flag when the chronometer's ring ends. All timing is counted in `CLK_Ring` periods.

## Interface
- `RING_TICKS`, 60: maximum ring length in `CLK_Ring` cycles before auto-stop (≥2).
- `SNOOZE_TICKS`, 300: snooze wait in cycles (≥2).
- `MAX_SNOOZE`, 3: snoozes allowed per alarm event.
- `CNT_W`, 9: counter width; must hold `max(RING_TICKS, SNOOZE_TICKS)`.
- `CLK_Ring` input 1: ring clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `fin_crono` input 1: chronometer finished (level, held until `clr_crono`).
- `alarm_hit` input 1: clock-alarm time match (level).
- `ack` input 1: dismiss (already synchronised, one cycle).
- `snooze` input 1: snooze request (already synchronised, one cycle).
- `ring_en` output 1: indicator granted and ringing.
- `band_parp` output 1: blink flag, toggles every cycle while ringing.
- `src` output 1: current or last grant; 0 = chronometer, 1 = alarm.
- `clr_crono` output 1: one-cycle pulse that clears the chronometer finish flag.
- `snoozing` output 1: an alarm snooze is in progress (including while frozen).
- `missed` output 1: sticky; a ring ended by timeout.

## Operation
- Rising edges are detected against registered previous values. Previous-value registers reset to 0, so an input that is high when reset releases counts as an edge.
- Each edge sets a pending flag: `pend_c` or `pend_a`. A flag is cleared when its source is granted.
- States:
  - IDLE: `ring_en`=0, `band_parp`=0.
    - If `pend_c` or a crono edge is present, go to RING with `src`=0.
    - Otherwise, if `pend_a` or an alarm edge is present, go to RING with `src`=1.
    - The chronometer wins any tie. The losing source stays pending.
  - RING: `ring_en`=1. `band_parp`=1 in the first cycle, inverted every following cycle. The ring counter increments every cycle. Exit conditions in priority order:
    - `ack`: dismiss.
    - `snooze`, only when `src`=1 and the snooze count is below `MAX_SNOOZE`: go to SNOOZE, increment the snooze count, load the snooze counter. `snooze` is ignored when `src`=0 or the limit is reached.
    - Counter reaches `RING_TICKS`: timeout. Set `missed`, then dismiss.
  - Dismiss from RING:
    - If `src`=0, pulse `clr_crono`.
    - If `src`=0 and a snooze is frozen, return to SNOOZE. Otherwise go to IDLE.
    - If `src`=1, clear the snooze count.
  - SNOOZE: `ring_en`=0, `snoozing`=1, and the snooze counter runs.
    - `ack` cancels the alarm: clear the snooze count and go to IDLE.
    - A crono edge or `pend_c` freezes the snooze counter and goes to RING with `src`=0. The alarm snooze resumes when that ring is dismissed.
    - Snooze counter reaches `SNOOZE_TICKS`: go to RING with `src`=1 and a fresh ring counter.
- Alarm edges that arrive while the alarm is ringing or snoozed are discarded, not pended.
- `missed` is cleared by the next `ack` that dismisses a ring.

## Timing
- Reset values: `ring_en`=0, `band_parp`=0, `src`=0, `clr_crono`=0, `snoozing`=0, `missed`=0. State is IDLE; all counters and pending flags are 0. Reset acts immediately, including mid-ring or mid-snooze; no `clr_crono` pulse is issued on reset.
- Grant latency: an edge sampled at clock edge k in IDLE gives `ring_en`=1 and `band_parp`=1 after edge k.
- Ring length with no ack: `ring_en` is high for exactly `RING_TICKS` cycles.
- Ack sampled at edge k: `ring_en`=0 after edge k. If `src`=0, `clr_crono`=1 for exactly the cycle after edge k.
- Back-to-back grants: after dismissal, a pending source is granted at the next edge. IDLE lasts exactly one cycle between the two rings.
- Snooze length: `ring_en` stays low for exactly `SNOOZE_TICKS` cycles (frozen cycles excluded) before the ring restarts.
- Simultaneous `ack` and `snooze` in the same cycle: `ack` wins.

## Test plan
- `fin_crono` rises, no ack, `RING_TICKS`=60 → `ring_en` high for 60 cycles, `band_parp` reads 1,0,1,… starting at 1, then `missed`=1 and one `clr_crono` pulse.
- `alarm_hit` and `fin_crono` rise in the same cycle, ack each ring on its 5th cycle → crono ring, `clr_crono` pulse, one IDLE cycle, then alarm ring with `src`=1.
- Alarm ringing, `snooze` on cycle 3, `SNOOZE_TICKS`=300 → `ring_en` low for exactly 300 cycles with `snoozing`=1, then rings again. A 4th `snooze` (limit 3) is ignored.
- Alarm snoozed, `fin_crono` rises at snooze cycle 100, ack the crono ring after 10 cycles → snooze resumes and re-rings after 200 more low cycles.
- Snooze requested during a crono ring → ignored. Ack in SNOOZE → IDLE, `snoozing`=0, no re-ring.
- `reset` asserted mid-ring with `fin_crono` still high → all outputs 0 immediately. On release, the crono edge is detected and the ring starts one cycle later.
